// File: rtl/cache_req_arbiter_if.sv
// Requester A/B and cache command bus for cache_req_arbiter.
// slave = arbiter view, master = requesters plus cache view.
interface cache_req_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              a_err;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_err;

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_done;
    logic [DATA_W-1:0] c_rdata;
    logic              c_hit;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata, a_err,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata, b_err,
        output c_req, c_we, c_addr, c_wdata,
        input  c_done, c_rdata, c_hit
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata, a_err,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata, b_err,
        input  c_req, c_we, c_addr, c_wdata,
        output c_done, c_rdata, c_hit
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin two-requester front end for a single-ported cache.
// Optional hit/miss/timeout counters: define CACHE_ARB_STATS_EN.
module cache_req_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic clk,
    input  logic reset,
    cache_req_arbiter_if.slave bus
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt,
    output logic [15:0] tmo_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic              last_b;
    logic              gnt_b;
    logic              win_b;
    logic [15:0]       wd;
    logic              done_acc;
    logic              tmo_hit;
    logic [DATA_W-1:0] rd_cap;

    logic              c_req_q;
    logic              c_we_q;
    logic [ADDR_W-1:0] c_addr_q;
    logic [DATA_W-1:0] c_wdata_q;
    logic              a_ack_q;
    logic              b_ack_q;
    logic              a_err_q;
    logic              b_err_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    assign win_b    = bus.b_req & (~bus.a_req | ~last_b);
    assign done_acc = (state == WAIT) & bus.c_done;
    assign tmo_hit  = (state == WAIT) & ~bus.c_done
                    & (wd == 16'(TIMEOUT - 1));
    assign rd_cap   = (done_acc & ~c_we_q) ? bus.c_rdata : '0;

    assign bus.c_req   = c_req_q;
    assign bus.c_we    = c_we_q;
    assign bus.c_addr  = c_addr_q;
    assign bus.c_wdata = c_wdata_q;
    assign bus.a_ack   = a_ack_q;
    assign bus.a_err   = a_err_q;
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_ack   = b_ack_q;
    assign bus.b_err   = b_err_q;
    assign bus.b_rdata = b_rdata_q;

    // Arbitration FSM with registered cache command and responses
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            gnt_b     <= 1'b0;
            wd        <= '0;
            c_req_q   <= 1'b0;
            c_we_q    <= 1'b0;
            c_addr_q  <= '0;
            c_wdata_q <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.a_req | bus.b_req) begin
                        gnt_b     <= win_b;
                        c_req_q   <= 1'b1;
                        c_we_q    <= win_b ? bus.b_we : bus.a_we;
                        c_addr_q  <= win_b ? bus.b_addr : bus.a_addr;
                        c_wdata_q <= win_b ? bus.b_wdata : bus.a_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    c_req_q <= 1'b0;
                    wd      <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (done_acc | tmo_hit) begin
                        c_we_q    <= 1'b0;
                        c_addr_q  <= '0;
                        c_wdata_q <= '0;
                        if (gnt_b) begin
                            b_ack_q   <= 1'b1;
                            b_err_q   <= tmo_hit;
                            b_rdata_q <= rd_cap;
                        end else begin
                            a_ack_q   <= 1'b1;
                            a_err_q   <= tmo_hit;
                            a_rdata_q <= rd_cap;
                        end
                        state <= RESP;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                RESP: begin
                    a_ack_q   <= 1'b0;
                    b_ack_q   <= 1'b0;
                    a_err_q   <= 1'b0;
                    b_err_q   <= 1'b0;
                    a_rdata_q <= '0;
                    b_rdata_q <= '0;
                    last_b    <= gnt_b;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_ARB_STATS_EN
    // Saturating hit/miss/timeout statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (done_acc && bus.c_hit && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            if (done_acc && !bus.c_hit && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
            if (tmo_hit && tmo_cnt != 16'hFFFF)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter.
// Bench acts as both requesters and as the cache.
module tb_cache_req_arbiter;
    localparam int TO = 24;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    bit   pend_a, pend_b, last_b_m;
    int   m_hit, m_miss, m_tmo;
    bit   wb;

    always #5 clk = ~clk;

    cache_req_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef CACHE_ARB_STATS_EN
    logic [15:0] hit_cnt, miss_cnt, tmo_cnt;
`endif

    cache_req_arbiter #(
        .TIMEOUT(TO), .ADDR_W(16), .DATA_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef CACHE_ARB_STATS_EN
        ,
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt),
        .tmo_cnt(tmo_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ack"}, 32'({bus.a_ack, bus.b_ack}), 0);
        chk({tag, "_err"}, 32'({bus.a_err, bus.b_err}), 0);
        chk({tag, "_ard"}, 32'(bus.a_rdata), 0);
        chk({tag, "_brd"}, 32'(bus.b_rdata), 0);
        chk({tag, "_creq"}, 32'({bus.c_req, bus.c_we}), 0);
        chk({tag, "_caddr"}, 32'(bus.c_addr), 0);
        chk({tag, "_cwd"}, 32'(bus.c_wdata), 0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.a_req  = 0;
        bus.b_req  = 0;
        bus.c_done = 0;
        pend_a     = 0;
        pend_b     = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        last_b_m = 1;
        m_hit    = 0;
        m_miss   = 0;
        m_tmo    = 0;
    endtask

    task automatic present(input bit is_b, input logic we,
                           input logic [15:0] ad, input logic [15:0] wd);
        if (is_b) begin
            bus.b_we = we; bus.b_addr = ad; bus.b_wdata = wd; pend_b = 1;
        end else begin
            bus.a_we = we; bus.a_addr = ad; bus.a_wdata = wd; pend_a = 1;
        end
    endtask

    // Called on a negedge in IDLE; returns on the negedge of the next IDLE.
    // lat: WAIT cycle index of c_done (0 = first WAIT cycle), <0 = never.
    task automatic txn(input int lat, input logic [15:0] rd,
                       input logic hit, input bit stray, output bit w);
        bit          we, err;
        logic [15:0] ad, wdv, erd;
        int          k, exp_k;
        bus.a_req = pend_a;
        bus.b_req = pend_b;
        w     = pend_b && (!pend_a || !last_b_m);
        we    = w ? bus.b_we : bus.a_we;
        ad    = w ? bus.b_addr : bus.a_addr;
        wdv   = w ? bus.b_wdata : bus.a_wdata;
        err   = !(lat >= 0 && lat < TO);
        exp_k = err ? TO : lat + 1;
        erd   = (err || we) ? 16'h0 : rd;
        @(posedge clk);
        @(negedge clk);
        chk("issue_req", 32'(bus.c_req), 1);
        chk("issue_we", 32'(bus.c_we), 32'(we));
        chk("issue_addr", 32'(bus.c_addr), 32'(ad));
        chk("issue_wdata", 32'(bus.c_wdata), 32'(wdv));
        bus.c_done  = stray;
        bus.c_rdata = 16'hDEAD;
        bus.c_hit   = 1'b1;
        @(posedge clk);
        k = 0;
        while (k <= TO + 4) begin
            @(negedge clk);
            bus.c_done = 0;
            if (bus.a_ack || bus.b_ack) break;
            chk("wait_req", 32'(bus.c_req), 0);
            chk("wait_addr", 32'(bus.c_addr), 32'(ad));
            chk("wait_we", 32'(bus.c_we), 32'(we));
            if (k == lat) begin
                bus.c_done  = 1;
                bus.c_rdata = rd;
                bus.c_hit   = hit;
            end
            @(posedge clk);
            k++;
        end
        chk("ack_cycle", 32'(k), 32'(exp_k));
        chk("a_ack", 32'(bus.a_ack), 32'(!w));
        chk("b_ack", 32'(bus.b_ack), 32'(w));
        chk("rdata", 32'(w ? bus.b_rdata : bus.a_rdata), 32'(erd));
        chk("err", 32'(w ? bus.b_err : bus.a_err), 32'(err));
        chk("other_rd", 32'(w ? bus.a_rdata : bus.b_rdata), 0);
        chk("other_err", 32'(w ? bus.a_err : bus.b_err), 0);
        last_b_m = w;
        if (w) begin pend_b = 0; bus.b_req = 0; end
        else begin pend_a = 0; bus.a_req = 0; end
        if (err) m_tmo++;
        else if (hit) m_hit++;
        else m_miss++;
        @(posedge clk);
        @(negedge clk);
        chk_quiet("idle");
    endtask

    initial begin
        bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
        bus.c_rdata = 0; bus.c_hit = 0;
        do_reset();
        chk_quiet("reset");

        // Single A read, fastest cache response
        present(0, 0, 16'h0010, 16'h0);
        txn(0, 16'd156, 0, 0, wb);
        chk("a_read_gnt", 32'(wb), 0);

        // Both requesting from reset: A, B, A, B
        do_reset();
        present(0, 0, 16'h0100, 16'h0);
        present(1, 0, 16'h0200, 16'h0);
        for (int i = 0; i < 4; i++) begin
            txn(1 + i, 16'(16'h0A00 + i), 1, 0, wb);
            chk("rr_order", 32'(wb), 32'(i % 2));
            if (i < 2) present(wb, 0, 16'(16'h0300 + i), 16'h0);
        end

        // B write with slow completion
        present(1, 1, 16'h0080, 16'h1234);
        txn(19, 16'hBEEF, 0, 0, wb);
        chk("b_write_gnt", 32'(wb), 1);

        // Timeout, late stray c_done, then a normal read
        present(0, 0, 16'h0040, 16'h0);
        txn(-1, 16'h5555, 0, 0, wb);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.c_done  = 1;
        bus.c_rdata = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        bus.c_done = 0;
        chk_quiet("stray");
        present(0, 0, 16'h0044, 16'h0);
        txn(2, 16'h4242, 1, 0, wb);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int lat, r;
            if (!pend_a && $urandom_range(0, 9) < 6)
                present(0, 1'($urandom), 16'($urandom), 16'($urandom));
            if (!pend_b && $urandom_range(0, 9) < 6)
                present(1, 1'($urandom), 16'($urandom), 16'($urandom));
            if (!pend_a && !pend_b)
                present(1'($urandom), 1'($urandom), 16'($urandom),
                        16'($urandom));
            r = $urandom_range(0, 19);
            if (r == 0) lat = -1;
            else if (r == 1) lat = TO - 1;
            else if (r == 2) lat = TO;
            else lat = $urandom_range(0, 8);
            txn(lat, 16'($urandom), 1'($urandom), 1'($urandom), wb);
        end
        while (pend_a || pend_b) txn(1, 16'h1111, 1, 0, wb);

`ifdef CACHE_ARB_STATS_EN
        chk("rand_hit", 32'(hit_cnt), 32'(m_hit));
        chk("rand_miss", 32'(miss_cnt), 32'(m_miss));
        chk("rand_tmo", 32'(tmo_cnt), 32'(m_tmo));
        do_reset();
        for (int i = 0; i < 6; i++) begin
            present(1'(i % 2), 0, 16'(i), 16'h0);
            txn((i == 5) ? -1 : i, 16'(i), 1'(i < 3), 0, wb);
        end
        chk("stat_hit", 32'(hit_cnt), 3);
        chk("stat_miss", 32'(miss_cnt), 2);
        chk("stat_tmo", 32'(tmo_cnt), 1);
`endif

        // Reset pulse while waiting on the cache
        present(0, 0, 16'h0900, 16'h0);
        bus.a_req = 1;
        @(posedge clk); @(negedge clk);
        chk("rst_issue", 32'(bus.c_req), 1);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        reset = 1;
        @(posedge clk); @(negedge clk);
        reset     = 0;
        bus.a_req = 0;
        pend_a    = 0;
        last_b_m  = 1;
        chk_quiet("rst_mid");
`ifdef CACHE_ARB_STATS_EN
        chk("rst_hit", 32'(hit_cnt), 0);
        chk("rst_miss", 32'(miss_cnt), 0);
        chk("rst_tmo", 32'(tmo_cnt), 0);
`endif
        bus.c_done  = 1;
        bus.c_rdata = 16'h3333;
        @(posedge clk); @(negedge clk);
        bus.c_done = 0;
        chk_quiet("rst_late");
        @(posedge clk); @(negedge clk);
        chk_quiet("rst_late2");

        // After reset A wins a tie again
        present(0, 0, 16'h0A0A, 16'h0);
        present(1, 0, 16'h0B0B, 16'h0);
        txn(3, 16'hCAFE, 0, 0, wb);
        chk("post_rst_gnt", 32'(wb), 0);
        txn(0, 16'hF00D, 0, 0, wb);
        chk("post_rst_gnt2", 32'(wb), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
